// File: rtl/memory_stage_if.sv
// Execution-to-writeback memory stage bundle: upstream op, data-cache handshake, writeback outputs.
// The slave modport is the memory stage itself; the master modport is its environment.
interface memory_stage_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    logic [DATA_WIDTH-1:0]     exu_result;
    logic [DATA_WIDTH-1:0]     mem_data;
    logic                      mem_valid;
    logic                      mem_write;
    logic                      mem_to_reg;
    logic                      cache_flush;
    logic [REG_ADDR_WIDTH-1:0] write_addr;
    logic                      write_en;
    logic                      halt;
    logic                      stall;

    logic                      cache_req;
    logic [DATA_WIDTH-1:0]     cache_addr;
    logic [DATA_WIDTH-1:0]     cache_wdata;
    logic                      cache_we;
    logic                      cache_flush_req;
    logic                      cache_ack;
    logic [DATA_WIDTH-1:0]     cache_rdata;
    logic                      cache_flush_done;

    logic [DATA_WIDTH-1:0]     wb_data;
    logic [REG_ADDR_WIDTH-1:0] wb_addr;
    logic                      wb_en;
    logic                      wb_halt;
    logic                      mem_error;

    modport slave (
        input  exu_result, mem_data, mem_valid, mem_write, mem_to_reg, cache_flush,
               write_addr, write_en, halt, cache_ack, cache_rdata, cache_flush_done,
        output stall, cache_req, cache_addr, cache_wdata, cache_we, cache_flush_req,
               wb_data, wb_addr, wb_en, wb_halt, mem_error
    );

    modport master (
        output exu_result, mem_data, mem_valid, mem_write, mem_to_reg, cache_flush,
               write_addr, write_en, halt, cache_ack, cache_rdata, cache_flush_done,
        input  stall, cache_req, cache_addr, cache_wdata, cache_we, cache_flush_req,
               wb_data, wb_addr, wb_en, wb_halt, mem_error
    );
endinterface

// File: rtl/memory_stage.sv
// Memory pipeline stage: runs the data-cache load/store/flush handshake, stalls upstream until
// each op completes (min one wait cycle), registers the writeback bundle, aborts on timeout.
module memory_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          clk,
    input  logic          rst,
    memory_stage_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    // Last waiting cycle index; an ack or done arriving on it still completes the op.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, FLUSH = 2'd2} state_t;

    state_t                    state_q, state_d;
    logic [CW-1:0]             wait_cnt;
    logic                      timeout;
    logic [DATA_WIDTH-1:0]     lat_result;
    logic                      lat_to_reg;
    logic [REG_ADDR_WIDTH-1:0] lat_waddr;
    logic                      lat_wen;
    logic                      lat_halt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        bus.stall = 1'b0;
        timeout   = (wait_cnt == CNT_LAST);
        case (state_q)
            IDLE: begin
                bus.stall = bus.mem_valid | bus.cache_flush;
                if (bus.cache_flush)    state_d = FLUSH;
                else if (bus.mem_valid) state_d = ACCESS;
            end
            ACCESS: begin
                bus.stall = !bus.cache_ack;
                if (bus.cache_ack || timeout) state_d = IDLE;
            end
            FLUSH: begin
                bus.stall = !bus.cache_flush_done;
                if (bus.cache_flush_done || timeout) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt            <= '0;
            lat_result          <= '0;
            lat_to_reg          <= 1'b0;
            lat_waddr           <= '0;
            lat_wen             <= 1'b0;
            lat_halt            <= 1'b0;
            bus.cache_req       <= 1'b0;
            bus.cache_addr      <= '0;
            bus.cache_wdata     <= '0;
            bus.cache_we        <= 1'b0;
            bus.cache_flush_req <= 1'b0;
            bus.wb_data         <= '0;
            bus.wb_addr         <= '0;
            bus.wb_en           <= 1'b0;
            bus.wb_halt         <= 1'b0;
            bus.mem_error       <= 1'b0;
        end else begin
            // Bubble unless a branch below completes or passes an op through.
            bus.wb_en   <= 1'b0;
            bus.wb_halt <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.cache_flush || bus.mem_valid) begin
                        wait_cnt   <= '0;
                        lat_result <= bus.exu_result;
                        lat_to_reg <= bus.mem_to_reg & !bus.cache_flush;
                        lat_waddr  <= bus.write_addr;
                        lat_wen    <= bus.write_en;
                        lat_halt   <= bus.halt;
                    end
                    if (bus.cache_flush) begin
                        bus.cache_flush_req <= 1'b1;
                    end else if (bus.mem_valid) begin
                        bus.cache_req   <= 1'b1;
                        bus.cache_addr  <= bus.exu_result;
                        bus.cache_wdata <= bus.mem_data;
                        bus.cache_we    <= bus.mem_write;
                    end else begin
                        bus.wb_data <= bus.exu_result;
                        bus.wb_addr <= bus.write_addr;
                        bus.wb_en   <= bus.write_en;
                        bus.wb_halt <= bus.halt;
                    end
                end
                ACCESS: begin
                    if (bus.cache_ack) begin
                        bus.cache_req <= 1'b0;
                        bus.cache_we  <= 1'b0;
                        bus.wb_data   <= lat_to_reg ? bus.cache_rdata : lat_result;
                        bus.wb_addr   <= lat_waddr;
                        bus.wb_en     <= lat_wen;
                        bus.wb_halt   <= lat_halt;
                    end else if (timeout) begin
                        bus.cache_req <= 1'b0;
                        bus.cache_we  <= 1'b0;
                        bus.mem_error <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                FLUSH: begin
                    if (bus.cache_flush_done) begin
                        bus.cache_flush_req <= 1'b0;
                        bus.wb_data         <= lat_result;
                        bus.wb_addr         <= lat_waddr;
                        bus.wb_en           <= lat_wen;
                        bus.wb_halt         <= lat_halt;
                    end else if (timeout) begin
                        bus.cache_flush_req <= 1'b0;
                        bus.mem_error       <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: one DUT with the default timeout behind a cache responder and
// writeback scoreboard, plus a second DUT with TIMEOUT_CYCLES=4 driven directly.
module tb_memory_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    memory_stage_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();
    memory_stage_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) tbus ();

    memory_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .TIMEOUT_CYCLES(255)) dut (
        .clk(clk), .rst(rst), .bus(bus));
    memory_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .TIMEOUT_CYCLES(4)) dut_to (
        .clk(clk), .rst(rst), .bus(tbus));

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  addr;
        logic        halt;
    } wb_t;

    int          checks = 0;
    int          failures = 0;
    wb_t         exp_q[$];
    wb_t         got;
    wb_t         exp_e;
    logic        resp_en = 1'b1;
    int          ack_delay = 0;
    int          flush_delay = 4;
    logic [31:0] resp_rdata = 32'h0;
    int          req_age = 0;
    int          fl_age = 0;

    // Cache model: ack after ack_delay cycles of request, flush done after flush_delay cycles.
    always @(negedge clk) begin
        if (resp_en && !rst && bus.cache_req === 1'b1) begin
            bus.cache_ack   = (req_age == ack_delay);
            bus.cache_rdata = resp_rdata;
            req_age++;
        end else begin
            bus.cache_ack   = 1'b0;
            bus.cache_rdata = 32'h0;
            req_age         = 0;
        end
        if (resp_en && !rst && bus.cache_flush_req === 1'b1) begin
            bus.cache_flush_done = (fl_age == flush_delay);
            fl_age++;
        end else begin
            bus.cache_flush_done = 1'b0;
            fl_age               = 0;
        end
    end

    // Writeback scoreboard on the main DUT.
    always @(negedge clk) begin
        if (!rst && bus.wb_en === 1'b1) begin
            checks++;
            got = {bus.wb_data, bus.wb_addr, bus.wb_halt};
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_wb got data=%h addr=%0d halt=%b, required no write",
                         bus.wb_data, bus.wb_addr, bus.wb_halt);
            end else begin
                exp_e = exp_q.pop_front();
                if (got !== exp_e) begin
                    failures++;
                    $display("FAIL sb_wb got data=%h addr=%0d halt=%b, required data=%h addr=%0d halt=%b",
                             got.data, got.addr, got.halt, exp_e.data, exp_e.addr, exp_e.halt);
                end
            end
        end
    end

    task automatic idle_inputs();
        bus.exu_result = '0;  bus.mem_data = '0;   bus.mem_valid = 1'b0; bus.mem_write = 1'b0;
        bus.mem_to_reg = 1'b0; bus.cache_flush = 1'b0; bus.write_addr = '0; bus.write_en = 1'b0;
        bus.halt = 1'b0;
        tbus.exu_result = '0;  tbus.mem_data = '0;   tbus.mem_valid = 1'b0; tbus.mem_write = 1'b0;
        tbus.mem_to_reg = 1'b0; tbus.cache_flush = 1'b0; tbus.write_addr = '0; tbus.write_en = 1'b0;
        tbus.halt = 1'b0; tbus.cache_ack = 1'b0; tbus.cache_rdata = '0; tbus.cache_flush_done = 1'b0;
    endtask

    // Upstream model: present one op at a negedge, hold it while stall is high just before the edge.
    task automatic issue(input logic flush, input logic valid, input logic wr, input logic to_reg,
                         input logic [31:0] res, input logic [31:0] wdat, input logic [4:0] waddr,
                         input logic wen, input logic hlt,
                         output int edges, output int req_cyc, output int we_cyc, output int fl_cyc,
                         output logic [31:0] s_addr, output logic [31:0] s_wdata);
        logic s;
        wb_t  x;
        edges = 0; req_cyc = 0; we_cyc = 0; fl_cyc = 0; s_addr = '0; s_wdata = '0;
        if (wen) begin
            x.data = (valid && !flush && to_reg) ? resp_rdata : res;
            x.addr = waddr;
            x.halt = hlt;
            exp_q.push_back(x);
        end
        bus.cache_flush = flush; bus.mem_valid = valid; bus.mem_write = wr; bus.mem_to_reg = to_reg;
        bus.exu_result = res; bus.mem_data = wdat; bus.write_addr = waddr; bus.write_en = wen;
        bus.halt = hlt;
        do begin
            #4;
            s = bus.stall;
            if (bus.cache_req === 1'b1) begin
                req_cyc++;
                s_addr  = bus.cache_addr;
                s_wdata = bus.cache_wdata;
            end
            if (bus.cache_we === 1'b1) we_cyc++;
            if (bus.cache_flush_req === 1'b1) fl_cyc++;
            @(negedge clk);
            edges++;
        end while (s !== 1'b0 && edges < 400);
        if (s !== 1'b0) begin
            checks++; failures++;
            $display("FAIL issue_budget stall still %b after %0d cycles, required release", s, edges);
        end
        bus.cache_flush = 1'b0; bus.mem_valid = 1'b0; bus.write_en = 1'b0; bus.halt = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.cache_req, bus.cache_we, bus.cache_flush_req, bus.wb_en, bus.wb_halt, bus.mem_error} !== 6'b0) begin
            failures++; $display("FAIL reset_ctrl got %b, required 000000",
                {bus.cache_req, bus.cache_we, bus.cache_flush_req, bus.wb_en, bus.wb_halt, bus.mem_error});
        end
        checks++;
        if ({bus.cache_addr, bus.cache_wdata, bus.wb_data} !== 96'h0 || bus.wb_addr !== 5'd0) begin
            failures++; $display("FAIL reset_data got addr=%h wdata=%h wb=%h wbaddr=%0d, required all 0",
                bus.cache_addr, bus.cache_wdata, bus.wb_data, bus.wb_addr);
        end
        checks++;
        if ({tbus.cache_req, tbus.mem_error, tbus.wb_en, tbus.stall, bus.stall} !== 5'b0) begin
            failures++; $display("FAIL reset_misc got %b, required 00000",
                {tbus.cache_req, tbus.mem_error, tbus.wb_en, tbus.stall, bus.stall});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_alu_pass();
        int e, rq, we, fl;
        logic [31:0] a, d;
        issue(1'b0, 1'b0, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd3, 1'b1, 1'b0, e, rq, we, fl, a, d);
        checks++;
        if (e !== 1) begin failures++; $display("FAIL alu_stall got %0d edges, required 1", e); end
        checks++;
        if ({bus.wb_data, bus.wb_addr, bus.wb_en} !== {32'h1234, 5'd3, 1'b1}) begin
            failures++; $display("FAIL alu_wb got data=%h addr=%0d en=%b, required 1234/3/1",
                bus.wb_data, bus.wb_addr, bus.wb_en);
        end
        issue(1'b0, 1'b0, 1'b0, 1'b0, 32'hCAFE_0001, 32'h0, 5'd31, 1'b1, 1'b1, e, rq, we, fl, a, d);
        checks++;
        if (bus.wb_halt !== 1'b1) begin failures++; $display("FAIL alu_halt got %b, required 1", bus.wb_halt); end
        @(negedge clk);
        checks++;
        if ({bus.wb_en, bus.wb_halt} !== 2'b00) begin
            failures++; $display("FAIL alu_idle got en/halt=%b, required 00", {bus.wb_en, bus.wb_halt});
        end
    endtask

    task automatic test_load();
        int e, rq, we, fl;
        logic [31:0] a, d;
        ack_delay = 3; resp_rdata = 32'hDEAD_BEEF;
        issue(1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 5'd5, 1'b1, 1'b0, e, rq, we, fl, a, d);
        checks++;
        if (e !== 5 || rq !== 4) begin
            failures++; $display("FAIL load_stall got edges=%0d req_cycles=%0d, required 5/4", e, rq);
        end
        checks++;
        if (a !== 32'h100 || we !== 0) begin
            failures++; $display("FAIL load_req got addr=%h we_cycles=%0d, required 100/0", a, we);
        end
        checks++;
        if ({bus.wb_data, bus.wb_addr, bus.wb_en, bus.cache_req} !== {32'hDEAD_BEEF, 5'd5, 1'b1, 1'b0}) begin
            failures++; $display("FAIL load_wb got data=%h addr=%0d en=%b req=%b, required deadbeef/5/1/0",
                bus.wb_data, bus.wb_addr, bus.wb_en, bus.cache_req);
        end
    endtask

    task automatic test_store();
        int e, rq, we, fl;
        logic [31:0] a, d;
        ack_delay = 0;
        issue(1'b0, 1'b1, 1'b1, 1'b0, 32'h40, 32'hA5A5_A5A5, 5'd9, 1'b0, 1'b0, e, rq, we, fl, a, d);
        checks++;
        if (e !== 2 || we !== 1 || rq !== 1) begin
            failures++; $display("FAIL store_timing got edges=%0d we=%0d req=%0d, required 2/1/1", e, we, rq);
        end
        checks++;
        if (a !== 32'h40 || d !== 32'hA5A5_A5A5) begin
            failures++; $display("FAIL store_req got addr=%h data=%h, required 40/a5a5a5a5", a, d);
        end
        checks++;
        if ({bus.cache_we, bus.wb_en} !== 2'b00) begin
            failures++; $display("FAIL store_done got we/wb_en=%b, required 00", {bus.cache_we, bus.wb_en});
        end
        issue(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_BEEF, 32'h0, 5'd4, 1'b1, 1'b0, e, rq, we, fl, a, d);
        checks++;
        if (e !== 1) begin failures++; $display("FAIL store_next_accept got %0d edges, required 1", e); end
    endtask

    task automatic test_flush();
        int e, rq, we, fl;
        logic [31:0] a, d;
        flush_delay = 4;
        issue(1'b1, 1'b1, 1'b1, 1'b0, 32'h77, 32'h1, 5'd7, 1'b1, 1'b1, e, rq, we, fl, a, d);
        checks++;
        if (rq !== 0 || we !== 0) begin
            failures++; $display("FAIL flush_no_req got req=%0d we=%0d, required 0/0", rq, we);
        end
        checks++;
        if (fl !== 5 || e !== 6) begin
            failures++; $display("FAIL flush_timing got flush_cycles=%0d edges=%0d, required 5/6", fl, e);
        end
        checks++;
        if ({bus.wb_data, bus.wb_en, bus.wb_halt, bus.cache_flush_req, bus.cache_req} !== {32'h77, 4'b1100}) begin
            failures++; $display("FAIL flush_wb got data=%h en=%b halt=%b freq=%b req=%b, required 77/1/1/0/0",
                bus.wb_data, bus.wb_en, bus.wb_halt, bus.cache_flush_req, bus.cache_req);
        end
    endtask

    task automatic test_back_to_back();
        int e, rq, we, fl, kind;
        logic [31:0] a, d;
        for (int i = 0; i < 24; i++) begin
            kind       = $urandom_range(0, 3);
            ack_delay  = $urandom_range(0, 2);
            flush_delay = $urandom_range(0, 2);
            resp_rdata = $urandom;
            issue(kind == 3, kind == 1 || kind == 2, kind == 2, kind == 1 && $urandom_range(0, 1) == 1,
                  $urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), e, rq, we, fl, a, d);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL b2b_drain got %0d pending writebacks, required 0", exp_q.size());
        end
    endtask

    task automatic test_mid_reset();
        resp_en = 1'b0;
        bus.mem_valid = 1'b1; bus.exu_result = 32'h200; bus.write_addr = 5'd2; bus.write_en = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.cache_req !== 1'b1) begin failures++; $display("FAIL midrst_req got %b, required 1", bus.cache_req); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.cache_req, bus.wb_en, bus.cache_flush_req} !== 3'b000) begin
            failures++; $display("FAIL midrst_abort got req/wb_en/freq=%b, required 000",
                {bus.cache_req, bus.wb_en, bus.cache_flush_req});
        end
        @(negedge clk);
        rst = 1'b0;
        bus.mem_valid = 1'b0; bus.write_en = 1'b0;
        #4;
        checks++;
        if (bus.stall !== 1'b0) begin failures++; $display("FAIL midrst_idle got stall=%b, required 0", bus.stall); end
        @(negedge clk);
        checks++;
        if ({bus.cache_req, bus.wb_en} !== 2'b00) begin
            failures++; $display("FAIL midrst_after got req/wb_en=%b, required 00", {bus.cache_req, bus.wb_en});
        end
        resp_en = 1'b1;
    endtask

    task automatic test_timeout();
        int   n;
        logic saw_wb;
        tbus.mem_valid = 1'b1; tbus.exu_result = 32'h300; tbus.write_addr = 5'd6; tbus.write_en = 1'b1;
        @(negedge clk);
        tbus.mem_valid = 1'b0; tbus.write_en = 1'b0;
        n = 0; saw_wb = 1'b0;
        while (tbus.cache_req === 1'b1 && n < 20) begin
            if (tbus.wb_en === 1'b1) saw_wb = 1'b1;
            n++;
            @(negedge clk);
        end
        checks++;
        if (n !== 4) begin failures++; $display("FAIL timeout_len got %0d req cycles, required 4", n); end
        checks++;
        if ({tbus.mem_error, tbus.wb_en, saw_wb} !== 3'b100) begin
            failures++; $display("FAIL timeout_abort got err/wb_en/saw_wb=%b, required 100",
                {tbus.mem_error, tbus.wb_en, saw_wb});
        end
        tbus.cache_ack = 1'b1; tbus.cache_rdata = 32'h1111_2222;
        @(negedge clk);
        tbus.cache_ack = 1'b0;
        checks++;
        if ({tbus.cache_req, tbus.wb_en, tbus.mem_error, tbus.stall} !== 4'b0010) begin
            failures++; $display("FAIL timeout_late_ack got req/wb_en/err/stall=%b, required 0010",
                {tbus.cache_req, tbus.wb_en, tbus.mem_error, tbus.stall});
        end
        // Ack arriving on the last wait cycle completes the op.
        tbus.mem_valid = 1'b1; tbus.mem_to_reg = 1'b1; tbus.exu_result = 32'h304;
        tbus.write_addr = 5'd9; tbus.write_en = 1'b1;
        @(negedge clk);
        tbus.mem_valid = 1'b0; tbus.write_en = 1'b0; tbus.mem_to_reg = 1'b0;
        repeat (3) @(negedge clk);
        tbus.cache_ack = 1'b1; tbus.cache_rdata = 32'h0000_55AA;
        @(negedge clk);
        tbus.cache_ack = 1'b0;
        checks++;
        if ({tbus.wb_data, tbus.wb_addr, tbus.wb_en, tbus.cache_req, tbus.mem_error} !== {32'h55AA, 5'd9, 3'b101}) begin
            failures++; $display("FAIL timeout_edge_ack got data=%h addr=%0d en=%b req=%b err=%b, required 55aa/9/1/0/1",
                tbus.wb_data, tbus.wb_addr, tbus.wb_en, tbus.cache_req, tbus.mem_error);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (tbus.mem_error !== 1'b0) begin
            failures++; $display("FAIL timeout_err_clear got %b, required 0", tbus.mem_error);
        end
    endtask

    initial begin
        test_reset();
        test_alu_pass();
        test_load();
        test_store();
        test_flush();
        test_back_to_back();
        test_mid_reset();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
